// File: rtl/umi_xbar_ingress.sv
// Per-port crossbar ingress: two-entry packet FIFO, destination decode, registered one-hot
// request and payload. Optional saturating drop counter under UMI_XBAR_INGRESS_ERRCNT_EN.
module umi_xbar_ingress #(
  parameter int N        = 4,
  parameter int CW       = 32,
  parameter int AW       = 64,
  parameter int DW       = 512,
  parameter int IDOFFSET = 40,
  parameter int IDW      = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          umi_in_valid,
  output logic          umi_in_ready,
  input  logic [CW-1:0] umi_in_cmd,
  input  logic [AW-1:0] umi_in_dstaddr,
  input  logic [AW-1:0] umi_in_srcaddr,
  input  logic [DW-1:0] umi_in_data,
  output logic [N-1:0]  umi_out_request,
  input  logic          umi_out_ready,
  output logic [CW-1:0] umi_out_cmd,
  output logic [AW-1:0] umi_out_dstaddr,
  output logic [AW-1:0] umi_out_srcaddr,
  output logic [DW-1:0] umi_out_data,
  output logic          drop_err
`ifdef UMI_XBAR_INGRESS_ERRCNT_EN
  ,
  output logic [15:0]   drop_count
`endif
);

  localparam logic [N-1:0] ONE_HOT_BASE = N'(1);

  // FIFO storage; the decoded destination and its bad flag travel with the packet
  logic [CW-1:0]  mem_cmd     [2];
  logic [AW-1:0]  mem_dstaddr [2];
  logic [AW-1:0]  mem_srcaddr [2];
  logic [DW-1:0]  mem_data    [2];
  logic [IDW-1:0] mem_dest    [2];
  logic           mem_bad     [2];

  logic [1:0] count_r;
  logic       rptr_r;
  logic       wptr_r;

  logic [IDW-1:0] dest_in_s;
  logic           bad_in_s;
  logic           push_s;
  logic           pop_s;
  logic           head_bad_s;
  logic [1:0]     count_nxt_s;
  logic           rptr_nxt_s;
  logic           wptr_nxt_s;
  logic           from_in_s;
  logic           nxt_valid_s;
  logic           nxt_bad_s;
  logic [IDW-1:0] nxt_dest_s;
  logic [CW-1:0]  nxt_cmd_s;
  logic [AW-1:0]  nxt_dstaddr_s;
  logic [AW-1:0]  nxt_srcaddr_s;
  logic [DW-1:0]  nxt_data_s;

  // Next-state of the FIFO and of the head entry the output registers will present
  always_comb begin
    dest_in_s  = umi_in_dstaddr[IDOFFSET +: IDW];
    bad_in_s   = (dest_in_s >= IDW'(N));
    push_s     = umi_in_valid & umi_in_ready;
    head_bad_s = (count_r != 2'd0) & mem_bad[rptr_r];
    // A bad head leaves on its own; a good head leaves only on a grant of its request
    pop_s      = head_bad_s | (umi_out_ready & (|umi_out_request));
    rptr_nxt_s = rptr_r ^ pop_s;
    wptr_nxt_s = wptr_r ^ push_s;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + 2'd1;
      2'b01:   count_nxt_s = count_r - 2'd1;
      default: count_nxt_s = count_r;
    endcase
    nxt_valid_s = (count_nxt_s != 2'd0);
    // The incoming packet becomes the head when it lands in the slot the read pointer moves to
    from_in_s = push_s & (wptr_r == rptr_nxt_s);
    if (from_in_s) begin
      nxt_dest_s    = dest_in_s;
      nxt_bad_s     = bad_in_s;
      nxt_cmd_s     = umi_in_cmd;
      nxt_dstaddr_s = umi_in_dstaddr;
      nxt_srcaddr_s = umi_in_srcaddr;
      nxt_data_s    = umi_in_data;
    end else begin
      nxt_dest_s    = mem_dest[rptr_nxt_s];
      nxt_bad_s     = mem_bad[rptr_nxt_s];
      nxt_cmd_s     = mem_cmd[rptr_nxt_s];
      nxt_dstaddr_s = mem_dstaddr[rptr_nxt_s];
      nxt_srcaddr_s = mem_srcaddr[rptr_nxt_s];
      nxt_data_s    = mem_data[rptr_nxt_s];
    end
  end

  // Packet storage write port
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_cmd[wptr_r]     <= umi_in_cmd;
      mem_dstaddr[wptr_r] <= umi_in_dstaddr;
      mem_srcaddr[wptr_r] <= umi_in_srcaddr;
      mem_data[wptr_r]    <= umi_in_data;
      mem_dest[wptr_r]    <= dest_in_s;
      mem_bad[wptr_r]     <= bad_in_s;
    end
  end

  // FIFO control state and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r         <= 2'd0;
      rptr_r          <= 1'b0;
      wptr_r          <= 1'b0;
      umi_in_ready    <= 1'b0;
      umi_out_request <= '0;
      drop_err        <= 1'b0;
      umi_out_cmd     <= '0;
      umi_out_dstaddr <= '0;
      umi_out_srcaddr <= '0;
      umi_out_data    <= '0;
    end else begin
      count_r         <= count_nxt_s;
      rptr_r          <= rptr_nxt_s;
      wptr_r          <= wptr_nxt_s;
      umi_in_ready    <= (count_nxt_s != 2'd2);
      umi_out_request <= (nxt_valid_s & ~nxt_bad_s) ? (ONE_HOT_BASE << nxt_dest_s) : '0;
      drop_err        <= nxt_valid_s & nxt_bad_s;
      if (nxt_valid_s) begin
        umi_out_cmd     <= nxt_cmd_s;
        umi_out_dstaddr <= nxt_dstaddr_s;
        umi_out_srcaddr <= nxt_srcaddr_s;
        umi_out_data    <= nxt_data_s;
      end else begin
        umi_out_cmd     <= umi_out_cmd;
        umi_out_dstaddr <= umi_out_dstaddr;
        umi_out_srcaddr <= umi_out_srcaddr;
        umi_out_data    <= umi_out_data;
      end
    end
  end

`ifdef UMI_XBAR_INGRESS_ERRCNT_EN
  // Saturating count of discarded packets
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_count <= 16'd0;
    end else if (drop_err && (drop_count != 16'hFFFF)) begin
      drop_count <= drop_count + 16'd1;
    end else begin
      drop_count <= drop_count;
    end
  end
`endif

endmodule

// File: tb/tb_umi_xbar_ingress.sv
// Directed bench for umi_xbar_ingress: reset, routing, backpressure, drops, streaming, reset
// mid-operation and (with UMI_XBAR_INGRESS_ERRCNT_EN) drop counter saturation.
module tb_umi_xbar_ingress;

  logic         clk;
  logic         reset;
  logic         umi_in_valid;
  logic         umi_in_ready;
  logic [31:0]  umi_in_cmd;
  logic [63:0]  umi_in_dstaddr;
  logic [63:0]  umi_in_srcaddr;
  logic [511:0] umi_in_data;
  logic [3:0]   umi_out_request;
  logic         umi_out_ready;
  logic [31:0]  umi_out_cmd;
  logic [63:0]  umi_out_dstaddr;
  logic [63:0]  umi_out_srcaddr;
  logic [511:0] umi_out_data;
  logic         drop_err;
`ifdef UMI_XBAR_INGRESS_ERRCNT_EN
  logic [15:0]  drop_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  umi_xbar_ingress dut (
    .clk             (clk),
    .reset           (reset),
    .umi_in_valid    (umi_in_valid),
    .umi_in_ready    (umi_in_ready),
    .umi_in_cmd      (umi_in_cmd),
    .umi_in_dstaddr  (umi_in_dstaddr),
    .umi_in_srcaddr  (umi_in_srcaddr),
    .umi_in_data     (umi_in_data),
    .umi_out_request (umi_out_request),
    .umi_out_ready   (umi_out_ready),
    .umi_out_cmd     (umi_out_cmd),
    .umi_out_dstaddr (umi_out_dstaddr),
    .umi_out_srcaddr (umi_out_srcaddr),
    .umi_out_data    (umi_out_data),
    .drop_err        (drop_err)
`ifdef UMI_XBAR_INGRESS_ERRCNT_EN
    ,
    .drop_count      (drop_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] addr_of(input int id);
    return (64'(id) << 40) | 64'h0000_0000_0000_1234;
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input int id, input logic [31:0] cmd);
    umi_in_valid   = 1'b1;
    umi_in_cmd     = cmd;
    umi_in_dstaddr = addr_of(id);
    umi_in_srcaddr = {32'h5A5A_0000, cmd};
    umi_in_data    = {16{cmd}};
  endtask

  task automatic chk_head(input string tag, input logic [3:0] req, input int id,
                          input logic [31:0] cmd);
    chk({tag, "_req"}, 512'(umi_out_request), 512'(req));
    chk({tag, "_cmd"}, 512'(umi_out_cmd), 512'(cmd));
    chk({tag, "_dst"}, 512'(umi_out_dstaddr), 512'(addr_of(id)));
    chk({tag, "_src"}, 512'(umi_out_srcaddr), 512'({32'h5A5A_0000, cmd}));
    chk({tag, "_data"}, umi_out_data, {16{cmd}});
  endtask

  initial begin
    reset          = 1'b1;
    umi_in_valid   = 1'b0;
    umi_in_cmd     = 32'd0;
    umi_in_dstaddr = 64'd0;
    umi_in_srcaddr = 64'd0;
    umi_in_data    = 512'd0;
    umi_out_ready  = 1'b0;
    step();
    step();
    chk("rst_ready", 512'(umi_in_ready), 512'(1'b0));
    chk("rst_req", 512'(umi_out_request), 512'(4'b0000));
    chk("rst_drop", 512'(drop_err), 512'(1'b0));
    chk("rst_cmd", 512'(umi_out_cmd), 512'(32'd0));
    chk("rst_data", umi_out_data, 512'd0);
`ifdef UMI_XBAR_INGRESS_ERRCNT_EN
    chk("rst_cnt", 512'(drop_count), 512'(16'd0));
`endif
    reset = 1'b0;
    step();
    chk("post_rst_ready", 512'(umi_in_ready), 512'(1'b1));
    chk("post_rst_req", 512'(umi_out_request), 512'(4'b0000));

    // Single packet to port 2 with the crossbar always granting
    umi_out_ready = 1'b1;
    send(2, 32'hC000_0001);
    step();
    umi_in_valid = 1'b0;
    chk_head("t1_head", 4'b0100, 2, 32'hC000_0001);
    step();
    chk("t1_popped", 512'(umi_out_request), 512'(4'b0000));
    step();
    chk("t1_empty_req", 512'(umi_out_request), 512'(4'b0000));
    chk("t1_empty_ready", 512'(umi_in_ready), 512'(1'b1));

    // Backpressure: fill both entries, third packet waits at the input
    umi_out_ready = 1'b0;
    send(0, 32'hC000_0002);
    step();
    chk_head("t2_first", 4'b0001, 0, 32'hC000_0002);
    chk("t2_ready1", 512'(umi_in_ready), 512'(1'b1));
    send(1, 32'hC000_0003);
    step();
    chk("t2_full_ready", 512'(umi_in_ready), 512'(1'b0));
    chk_head("t2_hold1", 4'b0001, 0, 32'hC000_0002);
    send(3, 32'hC000_0004);
    step();
    chk("t2_still_full", 512'(umi_in_ready), 512'(1'b0));
    chk_head("t2_hold2", 4'b0001, 0, 32'hC000_0002);
    umi_out_ready = 1'b1;
    step();
    chk_head("t2_second", 4'b0010, 1, 32'hC000_0003);
    chk("t2_ready_back", 512'(umi_in_ready), 512'(1'b1));
    step();
    umi_in_valid = 1'b0;
    chk_head("t2_third", 4'b1000, 3, 32'hC000_0004);
    step();
    chk("t2_drained", 512'(umi_out_request), 512'(4'b0000));

    // Unroutable ID 7 between two ID 1 packets
    umi_out_ready = 1'b0;
    send(1, 32'hC000_0005);
    step();
    chk_head("t3_first", 4'b0010, 1, 32'hC000_0005);
    send(7, 32'hC000_0006);
    step();
    chk("t3_no_drop_yet", 512'(drop_err), 512'(1'b0));
    chk("t3_full", 512'(umi_in_ready), 512'(1'b0));
    send(1, 32'hC000_0007);
    umi_out_ready = 1'b1;
    step();
    chk("t3_bad_req", 512'(umi_out_request), 512'(4'b0000));
    chk("t3_drop", 512'(drop_err), 512'(1'b1));
    chk("t3_ready", 512'(umi_in_ready), 512'(1'b1));
    step();
    umi_in_valid = 1'b0;
    chk("t3_drop_end", 512'(drop_err), 512'(1'b0));
    chk_head("t3_last", 4'b0010, 1, 32'hC000_0007);
    step();
    chk("t3_drained", 512'(umi_out_request), 512'(4'b0000));
    chk("t3_drop_quiet", 512'(drop_err), 512'(1'b0));
`ifdef UMI_XBAR_INGRESS_ERRCNT_EN
    chk("t3_cnt", 512'(drop_count), 512'(16'd1));
`endif

    // Streaming with a grant every cycle: one packet per cycle in order
    umi_out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(i % 4, 32'hC000_0010 + 32'(i));
      step();
      chk("t4_ready", 512'(umi_in_ready), 512'(1'b1));
      chk_head("t4_pkt", 4'b0001 << (i % 4), i % 4, 32'hC000_0010 + 32'(i));
    end
    umi_in_valid = 1'b0;
    step();
    chk("t4_drained", 512'(umi_out_request), 512'(4'b0000));

    // Reset with two packets buffered
    umi_out_ready = 1'b0;
    send(0, 32'hC000_0020);
    step();
    send(2, 32'hC000_0021);
    step();
    umi_in_valid = 1'b0;
    chk("t5_full", 512'(umi_in_ready), 512'(1'b0));
    chk("t5_req", 512'(umi_out_request), 512'(4'b0001));
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t5_rst_req", 512'(umi_out_request), 512'(4'b0000));
    step();
    chk("t5_after_ready", 512'(umi_in_ready), 512'(1'b1));
    chk("t5_after_req", 512'(umi_out_request), 512'(4'b0000));
    umi_out_ready = 1'b1;
    step();
    chk("t5_no_stale", 512'(umi_out_request), 512'(4'b0000));
    chk("t5_no_drop", 512'(drop_err), 512'(1'b0));

`ifdef UMI_XBAR_INGRESS_ERRCNT_EN
    // Drop counter saturation
    umi_out_ready = 1'b0;
    send(7, 32'hC000_0030);
    for (int i = 0; i < 65540; i++) begin
      step();
    end
    umi_in_valid = 1'b0;
    step();
    step();
    step();
    chk("t6_sat", 512'(drop_count), 512'(16'hFFFF));
    chk("t6_quiet", 512'(drop_err), 512'(1'b0));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/umi_xbar_ingress.md
# umi_xbar_ingress

Per-port ingress stage placed directly upstream of each `umi_crossbar` input. It buffers incoming UMI packets in a two-entry FIFO, decodes the destination port from the packet's `dstaddr`, and presents a registered one-hot request vector plus a stable payload to the crossbar. Packets addressed to a nonexistent port are dropped and flagged, so the crossbar never sees an unroutable request.

## Interface
- `N`, 4: number of crossbar output ports; width of the request vector.
- `CW`, 32: command width.
- `AW`, 64: address width.
- `DW`, 512: data width.
- `IDOFFSET`, 40: bit position of the destination port ID within `dstaddr`.
- `IDW`, 16: width of the destination port ID field.

- `clk`  in  1: single clock; all logic is on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `umi_in_valid`  in  1: upstream packet valid.
- `umi_in_ready`  out  1: ingress can accept a packet.
- `umi_in_cmd`  in  CW: packet command.
- `umi_in_dstaddr`  in  AW: destination address.
- `umi_in_srcaddr`  in  AW: source address.
- `umi_in_data`  in  DW: packet data.
- `umi_out_request`  out  N: one-hot request to the crossbar (column of the crossbar's request matrix).
- `umi_out_ready`  in  1: crossbar accepted the head packet (the crossbar's `umi_in_ready` for this port).
- `umi_out_cmd`, `umi_out_dstaddr`, `umi_out_srcaddr`, `umi_out_data`  out  CW/AW/AW/DW: head-packet payload.
- `drop_err`  out  1: one-cycle pulse when an unroutable packet is discarded.
- `drop_count`  out  16: saturating drop counter. Present only with `UMI_XBAR_INGRESS_ERRCNT_EN`.

## Operation
- **FIFO.** Two entries. Each entry stores cmd, dstaddr, srcaddr, data, and a decoded destination ID.
  - Decode at push: `dest = umi_in_dstaddr[IDOFFSET +: IDW]`.
  - `bad = (dest >= N)`; the comparison is unsigned and made at full IDW width.
- **Push.** A packet is pushed when `umi_in_valid & umi_in_ready`. `umi_in_ready = !full`, driven from the registered count.
- **Routable head.** When the head entry is valid and not bad:
  - `umi_out_request = 1 << dest`.
  - Payload outputs carry the head entry.
  - Pop occurs when `umi_out_ready & |umi_out_request`.
- **Unroutable head.** When the head entry is valid and bad:
  - `umi_out_request = 0`.
  - The entry is popped unconditionally in that cycle.
  - `drop_err` pulses high for that cycle.
- **Empty.** `umi_out_request = 0`. Payload outputs hold their last value and are don't-care.
- **Hold rule.** Request and payload stay stable from assertion until the pop. `umi_out_ready` without a request is ignored.
- **Count update.**
  - Push and pop in the same cycle: count unchanged, and the new entry is written behind the head.
  - Push while full cannot occur.
  - Pop while empty cannot occur.
- **Pointers.** 1-bit read and write pointers that wrap modulo 2.

## Timing
- **Reset values.** `umi_in_ready=0` during reset and `1` from the first cycle after reset deasserts. All of the following reset to 0:
  - count and pointers;
  - `umi_out_request`;
  - `drop_err`;
  - `drop_count`;
  - payload outputs.
- **Latency.** A packet accepted at edge t drives `umi_out_request` from edge t+1 (registered, never combinational from `umi_in_*`). A bad packet accepted at t drops at t+1.
- **Throughput.** One packet per cycle sustained when the crossbar grants every cycle.
  - A full FIFO plus a pop at edge t makes `umi_in_ready=1` after t.
  - `umi_in_ready` never depends combinationally on `umi_out_ready`.
- **Reset mid-operation.** Buffered packets are discarded and no request remains asserted in the cycle after reset.
- **Multiple grants.** A multi-cycle grant on a single packet pops exactly one entry per granted cycle.

## Configuration
- `UMI_XBAR_INGRESS_ERRCNT_EN`
  - **Defined:** the `drop_count` port and a 16-bit counter exist. The counter increments on every `drop_err` and saturates at 0xFFFF.
  - **Undefined:** the port and counter are absent, and `drop_err` is the only error indication.

## Test plan
- Reset, then push dstaddr ID=2 with `umi_out_ready=1` → `umi_out_request=4'b0100` one cycle after accept, popped next edge, FIFO empty.
- Hold `umi_out_ready=0` and push three packets (IDs 0, 1, 3) → first two accepted, `umi_in_ready=0` after second, request stays `4'b0001` with a stable payload; release ready → packets emerge in order 0, 1, 3.
- Push ID=7 (N=4) between ID=1 packets → `drop_err` single pulse, request never shows bit for 7, both ID=1 packets delivered; with macro `drop_count=1`.
- Continuous valid with continuous grant and IDs cycling 0..3 → one packet per cycle, `umi_in_ready` never drops, output order matches input.
- Assert `reset` for one cycle with two packets buffered → next cycle `umi_out_request=0` and `umi_in_ready=1`, no stale packet emerges afterwards.
- With macro defined, send 65540 bad packets → `drop_count` saturates at 0xFFFF.
